// File: rtl/punchout_pkg.sv
// rtl/punchout_pkg.sv - shared lane, x-position, state and health definitions for punch-out
package punchout_pkg;

  localparam int HP_W = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_L = 2'b00;
  localparam lane_t LANE_C = 2'b01;
  localparam lane_t LANE_R = 2'b10;

  localparam logic [7:0] X_LANE_L = 8'd20;
  localparam logic [7:0] X_LANE_C = 8'd60;
  localparam logic [7:0] X_LANE_R = 8'd100;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DODGE   = 3'd1;
  localparam logic [2:0] ST_PUNCH   = 3'd2;
  localparam logic [2:0] ST_STUNNED = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Code 11 means "no lane"; it decodes to 0 so it is never drawn on a lane.
  function automatic logic [7:0] lane_to_x(input lane_t lane);
    case (lane)
      LANE_L:  lane_to_x = X_LANE_L;
      LANE_C:  lane_to_x = X_LANE_C;
      LANE_R:  lane_to_x = X_LANE_R;
      default: lane_to_x = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - one-cycle pulse on a low-to-high transition of a synchronized level
module rising_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_i;
  end

  // History clears to 0, so a level held through reset yields one pulse afterwards.
  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/player_combat.sv
// rtl/player_combat.sv - player-side combat FSM: lane moves, punches, strikes, health and winner
module player_combat
  import punchout_pkg::*;
#(
  parameter logic [HP_W-1:0] HEALTH_INIT  = 4'd7,
  parameter logic [27:0]     DODGE_CYCLES = 28'd12_500_000,
  parameter logic [27:0]     PUNCH_CYCLES = 28'd25_000_000,
  parameter logic [27:0]     STUN_CYCLES  = 28'd50_000_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      enemy_lane,
  input  logic            enemy_strike,
  input  logic            btn_left,
  input  logic            btn_right,
  input  logic            btn_punch,
  output logic [1:0]      player_lane,
  output logic [7:0]      player_x,
  output logic [2:0]      state,
  output logic [HP_W-1:0] player_hp,
  output logic [HP_W-1:0] enemy_hp,
  output logic            hit_player,
  output logic            hit_enemy,
  output logic            game_over,
  output logic            player_won
);

  logic left_edge, right_edge, punch_edge;

  rising_edge_detect u_left  (.clock(clock), .reset(reset), .level_i(btn_left),  .pulse_o(left_edge));
  rising_edge_detect u_right (.clock(clock), .reset(reset), .level_i(btn_right), .pulse_o(right_edge));
  rising_edge_detect u_punch (.clock(clock), .reset(reset), .level_i(btn_punch), .pulse_o(punch_edge));

  logic [2:0]      state_q, state_d;
  lane_t           lane_q, lane_d;
  logic [27:0]     cnt_q, cnt_d;
  logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d;
  logic            hit_player_q, hit_player_d, hit_enemy_q, hit_enemy_d;
  logic            over_q, over_d, won_q, won_d;

  logic            strike_hit;
  logic [HP_W-1:0] php_dec, ehp_dec;

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    php_d        = php_q;
    ehp_d        = ehp_q;
    hit_player_d = 1'b0;
    hit_enemy_d  = 1'b0;
    over_d       = over_q;
    won_d        = won_q;

    php_dec    = (php_q == '0) ? '0 : php_q - 1'b1;
    ehp_dec    = (ehp_q == '0) ? '0 : ehp_q - 1'b1;
    strike_hit = enemy_strike && (enemy_lane == lane_q) &&
                 (state_q != ST_STUNNED) && (state_q != ST_DONE);

    // A landed strike pre-empts everything, including a punch expiring this cycle.
    if (strike_hit) begin
      hit_player_d = 1'b1;
      php_d        = php_dec;
      if (php_dec == '0) begin
        state_d = ST_DONE;
        over_d  = 1'b1;
        won_d   = (ehp_q == '0);
      end else begin
        state_d = ST_STUNNED;
        cnt_d   = STUN_CYCLES - 28'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (left_edge ^ right_edge) begin
            if (left_edge && lane_q != LANE_L) begin
              lane_d  = lane_q - 2'd1;
              state_d = ST_DODGE;
              cnt_d   = DODGE_CYCLES - 28'd1;
            end else if (right_edge && lane_q != LANE_R) begin
              lane_d  = lane_q + 2'd1;
              state_d = ST_DODGE;
              cnt_d   = DODGE_CYCLES - 28'd1;
            end
          end else if (!left_edge && !right_edge && punch_edge) begin
            state_d = ST_PUNCH;
            cnt_d   = PUNCH_CYCLES - 28'd1;
          end
        end
        ST_DODGE, ST_STUNNED: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 28'd1;
        end
        ST_PUNCH: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            if (enemy_lane == lane_q) begin
              hit_enemy_d = 1'b1;
              ehp_d       = ehp_dec;
              if (ehp_dec == '0) begin
                state_d = ST_DONE;
                over_d  = 1'b1;
                won_d   = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q - 28'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lane_q       <= LANE_C;
      cnt_q        <= '0;
      php_q        <= HEALTH_INIT;
      ehp_q        <= HEALTH_INIT;
      hit_player_q <= 1'b0;
      hit_enemy_q  <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      php_q        <= php_d;
      ehp_q        <= ehp_d;
      hit_player_q <= hit_player_d;
      hit_enemy_q  <= hit_enemy_d;
      over_q       <= over_d;
      won_q        <= won_d;
    end
  end

  assign player_lane = lane_q;
  assign player_x    = lane_to_x(lane_q);
  assign state       = state_q;
  assign player_hp   = php_q;
  assign enemy_hp    = ehp_q;
  assign hit_player  = hit_player_q;
  assign hit_enemy   = hit_enemy_q;
  assign game_over   = over_q;
  assign player_won  = won_q;

endmodule

// File: tb/tb_player_combat.sv
// tb/tb_player_combat.sv - scoreboard bench for player_combat against a rule-level game model
module tb_player_combat;

  localparam int HP0   = 3;
  localparam int DODGE = 4;
  localparam int PUNCH = 3;
  localparam int STUN  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] enemy_lane = 2'd3;
  logic       enemy_strike = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_punch = 1'b0;
  logic [1:0] player_lane;
  logic [7:0] player_x;
  logic [2:0] state;
  logic [3:0] player_hp, enemy_hp;
  logic       hit_player, hit_enemy, game_over, player_won;

  player_combat #(
    .HEALTH_INIT(4'd3), .DODGE_CYCLES(28'd4), .PUNCH_CYCLES(28'd3), .STUN_CYCLES(28'd8)
  ) dut (
    .clock(clock), .reset(reset), .enemy_lane(enemy_lane), .enemy_strike(enemy_strike),
    .btn_left(btn_left), .btn_right(btn_right), .btn_punch(btn_punch),
    .player_lane(player_lane), .player_x(player_x), .state(state),
    .player_hp(player_hp), .enemy_hp(enemy_hp), .hit_player(hit_player),
    .hit_enemy(hit_enemy), .game_over(game_over), .player_won(player_won)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] x;
    logic [2:0] st;
    logic [3:0] php;
    logic [3:0] ehp;
    logic       hp;
    logic       he;
    logic       go;
    logic       won;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 dodge, 2 punch, 3 stunned, 4 done; spent counts cycles in the mode.
  int m_lane, m_mode, m_spent, m_php, m_ehp;
  bit m_go, m_won, m_hp_pulse, m_he_pulse;
  bit prev_l, prev_r, prev_p;

  function automatic snap_t model_snap();
    snap_t s;
    s.lane = 2'(m_lane);
    s.x    = 8'(20 + 40 * m_lane);
    s.st   = 3'(m_mode);
    s.php  = 4'(m_php);
    s.ehp  = 4'(m_ehp);
    s.hp   = m_hp_pulse;
    s.he   = m_he_pulse;
    s.go   = m_go;
    s.won  = m_won;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.lane = player_lane; s.x = player_x; s.st = state;
    s.php = player_hp; s.ehp = enemy_hp; s.hp = hit_player; s.he = hit_enemy;
    s.go = game_over; s.won = player_won;
    return s;
  endfunction

  task automatic model_reset();
    m_lane = 1; m_mode = 0; m_spent = 0; m_php = HP0; m_ehp = HP0;
    m_go = 0; m_won = 0; m_hp_pulse = 0; m_he_pulse = 0;
    prev_l = 0; prev_r = 0; prev_p = 0;
  endtask

  task automatic enter(input int mode);
    m_mode = mode; m_spent = 1;
  endtask

  task automatic model_step(input bit l, input bit r, input bit p, input int el, input bit st);
    bit le, re, pe, landed;
    le = l && !prev_l; re = r && !prev_r; pe = p && !prev_p;
    prev_l = l; prev_r = r; prev_p = p;
    m_hp_pulse = 0; m_he_pulse = 0;
    landed = st && (el == m_lane) && (m_mode <= 2);
    if (landed) begin
      m_hp_pulse = 1;
      if (m_php > 0) m_php--;
      if (m_php == 0) begin m_mode = 4; m_go = 1; m_won = (m_ehp == 0); end
      else enter(3);
    end else begin
      case (m_mode)
        0: begin
          if (le || re) begin
            if (le && !re && m_lane > 0)      begin m_lane--; enter(1); end
            else if (re && !le && m_lane < 2) begin m_lane++; enter(1); end
          end else if (pe) enter(2);
        end
        1: if (m_spent == DODGE) m_mode = 0; else m_spent++;
        3: if (m_spent == STUN)  m_mode = 0; else m_spent++;
        2: begin
          if (m_spent == PUNCH) begin
            m_mode = 0;
            if (el == m_lane) begin
              m_he_pulse = 1;
              if (m_ehp > 0) m_ehp--;
              if (m_ehp == 0) begin m_mode = 4; m_go = 1; m_won = 1; end
            end
          end else m_spent++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare(input string name, input snap_t act, input snap_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got lane=%0d x=%0d st=%0d php=%0d ehp=%0d hp=%b he=%b go=%b won=%b want lane=%0d x=%0d st=%0d php=%0d ehp=%0d hp=%b he=%b go=%b won=%b",
               name, $time, act.lane, act.x, act.st, act.php, act.ehp, act.hp, act.he, act.go, act.won,
               e.lane, e.x, e.st, e.php, e.ehp, e.hp, e.he, e.go, e.won);
    end
  endtask

  task automatic step(input bit l, input bit r, input bit p, input logic [1:0] el, input bit st);
    @(negedge clock);
    btn_left = l; btn_right = r; btn_punch = p; enemy_lane = el; enemy_strike = st;
    model_step(l, r, p, int'(el), st);
    exp_q.push_back(model_snap());
  endtask

  task automatic do_reset();
    snap_t rst_exp;
    rst_exp = '{lane: 2'd1, x: 8'd60, st: 3'd0, php: 4'd3, ehp: 4'd3,
                hp: 1'b0, he: 1'b0, go: 1'b0, won: 1'b0};
    @(posedge clock);
    #3;
    reset = 1'b1;
    btn_left = 0; btn_right = 0; btn_punch = 0; enemy_strike = 0; enemy_lane = 2'd3;
    #1 compare("async_reset", dut_snap(), rst_exp);
    repeat (2) @(posedge clock);
    #1 compare("held_reset", dut_snap(), rst_exp);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    model_step(0, 0, 0, 3, 0);
    exp_q.push_back(model_snap());
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_snap(), e);
      end
    end
  end

  initial begin : stimulus
    do_reset();
    // Lane moves, an ignored edge during DODGE, and a boundary move.
    repeat (4) step(0, 0, 0, 3, 0);
    step(1, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    step(1, 0, 0, 3, 0);
    repeat (4) step(0, 0, 0, 3, 0);
    step(1, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    // Punch landing, then a punch into an empty lane.
    step(0, 0, 1, 0, 0); repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0); repeat (4) step(0, 0, 0, 2, 0);
    // Strike in punch cycle 2, then a strike while stunned.
    step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1); repeat (8) step(0, 0, 0, 0, 0);
    // Strike coincident with punch expiry.
    step(0, 0, 1, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1);
    repeat (9) step(0, 0, 0, 0, 0);
    // Third landed strike, then activity in DONE.
    step(0, 0, 0, 0, 1); step(1, 0, 1, 0, 1); step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    do_reset();
    // Three landed punches.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0);
      repeat (3) step(0, 0, 0, 1, 0);
    end
    repeat (3) step(1, 1, 1, 1, 1);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      if (m_mode == 4 && $urandom_range(0, 5) == 0) do_reset();
    end
    repeat (3) @(posedge clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
